sha256_msg_pad: RTL and testbench
=================================

SHA256_MSG_PAD -- requirements
Module: sha256_msg_pad

Interface
REQ-001 SHALL have these ports: clk, input, 1, sole clock; all logic on posedge; mem_clk is driven from it.
REQ-002 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1, begin padding job; sampled only in IDLE.
REQ-004 SHALL have port message_addr, input, 32, word address of message word 0; sampled with start.
REQ-005 SHALL have port size, input, 32, message length in bytes; sampled with start.
REQ-006 SHALL have port mem_clk, output, 1, memory clock, equal to clk.
REQ-007 SHALL have port mem_we, output, 1, memory write enable, constant 0.
REQ-008 SHALL have port mem_addr, output, 16, read word address.
REQ-009 SHALL have port mem_read_data, input, 32, read data, valid the cycle after the address edge.
REQ-010 SHALL have port w_valid, output, 1, w_data holds a padded word.
REQ-011 SHALL have port w_ready, input, 1, consumer accepts the word; transfer = w_valid & w_ready at posedge.
REQ-012 SHALL have port w_data, output, 32, padded word, big-endian byte order.
REQ-013 SHALL have port w_eob, output, 1, high with word 15 of each 512-bit block.
REQ-014 SHALL have port w_last, output, 1, high with the final word of the final block.
REQ-015 SHALL have port done, output, 1, one-cycle pulse when the job completes.

Function
REQ-016 SHALL latch these at start: nfull=size/4, r=size%4, nblk=(size+8)/64+1, total=16*nblk.
REQ-017 SHALL emit word i, for i=0..total-1, in order as: i<nfull: mem[message_addr+i]; i==nfull: r=0 gives 0x80000000, r=1 gives mem&0xFF000000|0x00800000, r=2 gives mem&0xFFFF0000|0x00008000, r=3 gives mem&0xFFFFFF00|0x00000080; i==total-2: size>>29; i==total-1: size<<3 (32-bit truncation); otherwise 0.
REQ-018 SHALL compute mem_addr as (message_addr+i)[15:0], wrapping at 16 bits.
REQ-019 SHALL implement the FSM states IDLE, RD, WT, OUT, FIN.
REQ-020 SHALL take IDLE->RD on start when word 0 needs memory; otherwise IDLE->OUT with the generated word loaded.
REQ-021 SHALL drive mem_addr in RD, then go RD->WT.
REQ-022 SHALL register the formed word from mem_read_data in WT, then go WT->OUT.
REQ-023 SHALL hold w_valid=1 in OUT, with w_data, w_eob and w_last stable until transfer.
REQ-024 SHALL, on a non-final transfer, increment i and go to RD when the next word needs memory (i<nfull, or i==nfull with r!=0); otherwise it SHALL load the generated word and stay in OUT.
REQ-025 SHALL, on the final transfer, go OUT->FIN; FIN SHALL pulse done=1 for one cycle and go to IDLE.
REQ-026 SHALL give latencies of 3 cycles start->w_valid for a memory word and 1 cycle for a generated word; generated words SHALL sustain 1 word/cycle under w_ready=1.
REQ-027 SHALL ignore start outside IDLE; start held high in IDLE after FIN SHALL begin a new job.
REQ-028 SHALL treat size=0 as 1 block: word0=0x80000000, words 1..15=0.
REQ-029 SHALL treat size=55 as 1 block and size=56 as 2 blocks.

Reset
REQ-030 SHALL force state=IDLE, i=0, w_valid=0, w_data=0, w_eob=0, w_last=0, done=0, mem_addr=0 and mem_we=0 asynchronously on reset_n low.
REQ-031 SHALL abandon any job in progress when reset is asserted mid-job; no partial word is emitted after release.

Structure
REQ-032 SHALL place in shared package sha256_pkg: FSM state enum, BLOCK_WORDS=16, PAD_BYTE=0x80, and the pad-word mask function.
REQ-033 SHALL contain no sub-module; it is a single FSM plus counter, roughly 150-250 lines.

Verification
REQ-034 SHALL cover size=0 -> 16 words: 0x80000000 then 15 zeros; w_eob and w_last on word 15; done 1 cycle later.
REQ-035 SHALL cover size=3 with mem[0]=0x01234567 -> word0=0x01234580; word15=0x00000018.
REQ-036 SHALL cover size=120, seed 0x01234567 with each word rotated left by 1 -> 48 words; word30=0x80000000; word46=0; word47=0x000003C0; w_eob on words 15, 31 and 47.
REQ-037 SHALL cover w_ready held low 5 cycles in OUT -> w_data, w_eob and w_last unchanged; no mem_addr change; the word count is unaffected.
REQ-038 SHALL cover reset_n pulsed low at word 20 of a size=120 job -> all outputs 0 immediately; IDLE after release; a new start yields a correct full sequence.
REQ-039 SHALL cover size=56 and message_addr=0xFFFE -> 32 words; addresses 0xFFFE, 0xFFFF, 0x0000...; word14=0x80000000; word31=0x000001C0.

Source files
------------

// File: rtl/sha256_pkg.sv
// sha256_pkg: shared FSM state, block geometry and pad-word forming for the SHA-256 message padder.
package sha256_pkg;

    typedef enum logic [2:0] {IDLE, RD, WT, OUT, FIN} state_t;

    localparam int         BLOCK_WORDS = 16;
    localparam logic [7:0] PAD_BYTE    = 8'h80;

    // Keep the r leading message bytes of a big-endian word and place the pad byte right after them.
    function automatic logic [31:0] pad_word(input logic [31:0] data, input logic [1:0] r);
        logic [31:0] keep;
        keep = ~(32'hFFFF_FFFF >> {r, 3'b000});
        return (data & keep) | ({24'h0, PAD_BYTE} << {~r, 3'b000});
    endfunction

endpackage

// File: rtl/sha256_msg_pad.sv
// sha256_msg_pad: streams a SHA-256 padded message as big-endian 32-bit words read from
// word-addressed memory, appending the pad byte, zero fill and the 64-bit bit length.
module sha256_msg_pad
    import sha256_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] message_addr,
    input  logic [31:0] size,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    input  logic [31:0] mem_read_data,
    output logic        w_valid,
    input  logic        w_ready,
    output logic [31:0] w_data,
    output logic        w_eob,
    output logic        w_last,
    output logic        done
);

    state_t      state;
    logic [31:0] i, size_q, c_size, c_nfull, idx, gen_word, formed;
    logic [15:0] base, addr_nxt;
    logic [32:0] c_nblk, c_total, c_last, c_lenhi;
    logic [1:0]  c_r;
    logic        need_mem, xfer, nxt_eob, nxt_last, unused;

    assign mem_clk = clk;
    assign mem_we  = 1'b0;
    assign xfer    = w_valid && w_ready;
    assign unused  = ^message_addr[31:16];

    // In IDLE the job parameters come straight from the inputs so word 0 can be decided at start.
    always_comb begin
        c_size   = (state == IDLE) ? size : size_q;
        c_nfull  = {2'b00, c_size[31:2]};
        c_r      = c_size[1:0];
        c_nblk   = (({1'b0, c_size} + 33'd8) >> 6) + 33'd1;
        c_total  = c_nblk * 33'd16;
        c_last   = c_total - 33'd1;
        c_lenhi  = c_total - 33'd2;
        idx      = (state == IDLE) ? 32'd0 : i + 32'd1;
        addr_nxt = ((state == IDLE) ? message_addr[15:0] : base) + idx[15:0];
        need_mem = (idx < c_nfull) || (idx == c_nfull && c_r != 2'd0);
        gen_word = (idx == c_nfull)          ? {PAD_BYTE, 24'h0} :
                   ({1'b0, idx} == c_lenhi)  ? {29'd0, c_size[31:29]} :
                   ({1'b0, idx} == c_last)   ? {c_size[28:0], 3'b000} : 32'd0;
        nxt_eob  = idx[3:0] == 4'(BLOCK_WORDS - 1);
        nxt_last = {1'b0, idx} == c_last;
        formed   = (i < c_nfull) ? mem_read_data : pad_word(mem_read_data, c_r);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            i        <= 32'd0;
            base     <= 16'd0;
            size_q   <= 32'd0;
            mem_addr <= 16'd0;
            w_valid  <= 1'b0;
            w_data   <= 32'd0;
            w_eob    <= 1'b0;
            w_last   <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    base   <= message_addr[15:0];
                    size_q <= size;
                    i      <= 32'd0;
                    if (need_mem) begin
                        mem_addr <= addr_nxt;
                        state    <= RD;
                    end else begin
                        w_data  <= gen_word;
                        w_eob   <= nxt_eob;
                        w_last  <= nxt_last;
                        w_valid <= 1'b1;
                        state   <= OUT;
                    end
                end
                RD: state <= WT;
                WT: begin
                    w_data  <= formed;
                    w_eob   <= i[3:0] == 4'(BLOCK_WORDS - 1);
                    w_last  <= {1'b0, i} == c_last;
                    w_valid <= 1'b1;
                    state   <= OUT;
                end
                OUT: if (xfer) begin
                    if (w_last) begin
                        w_valid <= 1'b0;
                        w_eob   <= 1'b0;
                        w_last  <= 1'b0;
                        done    <= 1'b1;
                        state   <= FIN;
                    end else begin
                        i <= idx;
                        if (need_mem) begin
                            w_valid  <= 1'b0;
                            mem_addr <= addr_nxt;
                            state    <= RD;
                        end else begin
                            w_data <= gen_word;
                            w_eob  <= nxt_eob;
                            w_last <= nxt_last;
                        end
                    end
                end
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_pad.sv
// tb_sha256_msg_pad: directed padding jobs against a rotating-seed memory, checked with immediate assertions.
module tb_sha256_msg_pad;

    localparam logic [31:0] SEED = 32'h0123_4567;

    logic        clk = 1'b0;
    logic        reset_n, start, mem_clk, mem_we, w_valid, w_ready, w_eob, w_last, done;
    logic [31:0] message_addr, size, mem_read_data, w_data;
    logic [15:0] mem_addr;

    logic [31:0] got_data [64];
    logic        got_eob  [64];
    logic        got_last [64];
    logic [15:0] got_addr [64];
    int          n, lat, last_cyc;
    int          vectors = 0;
    int          errs    = 0;

    always #5 clk = ~clk;

    sha256_msg_pad dut (
        .clk(clk), .reset_n(reset_n), .start(start), .message_addr(message_addr), .size(size),
        .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr), .mem_read_data(mem_read_data),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_eob(w_eob), .w_last(w_last),
        .done(done)
    );

    // Memory word at address a is the seed rotated left a[4:0] times.
    function automatic logic [31:0] memf(input logic [15:0] a);
        logic [31:0] x;
        x = SEED;
        for (int k = 0; k < int'(a[4:0]); k++) x = {x[30:0], x[31]};
        return x;
    endfunction

    always @(posedge mem_clk) mem_read_data <= memf(mem_addr);

    function automatic logic [31:0] ref_word(input int j, input logic [31:0] a, input logic [31:0] sz);
        int          nf, r, tot;
        logic [31:0] ad, m;
        nf  = int'(sz) / 4;
        r   = int'(sz) % 4;
        tot = 16 * ((int'(sz) + 8) / 64 + 1);
        ad  = a + 32'(j);
        m   = memf(ad[15:0]);
        if (j < nf) return m;
        if (j == nf)
            return (r == 0) ? 32'h8000_0000 :
                   (r == 1) ? ((m & 32'hFF00_0000) | 32'h0080_0000) :
                   (r == 2) ? ((m & 32'hFFFF_0000) | 32'h0000_8000) :
                              ((m & 32'hFFFF_FF00) | 32'h0000_0080);
        if (j == tot - 2) return sz >> 29;
        if (j == tot - 1) return sz << 3;
        return 32'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_valid"}, 32'(w_valid), 32'd0);
        chk({tag, "_data"},  w_data,       32'd0);
        chk({tag, "_eob"},   32'(w_eob),   32'd0);
        chk({tag, "_last"},  32'(w_last),  32'd0);
        chk({tag, "_done"},  32'(done),    32'd0);
        chk({tag, "_addr"},  32'(mem_addr), 32'd0);
        chk({tag, "_we"},    32'(mem_we),  32'd0);
    endtask

    task automatic run_job(input logic [31:0] a, input logic [31:0] sz, input int stall_at, input int abort_at);
        int          tot, cyc, stall;
        logic [31:0] s_data;
        logic [15:0] s_addr;
        logic        s_eob, s_last;
        tot = 16 * ((int'(sz) + 8) / 64 + 1);
        n = 0; lat = -1; last_cyc = 0; cyc = 0; stall = stall_at;
        w_ready = 1'b1;
        @(negedge clk);
        message_addr = a; size = sz; start = 1'b1;
        while (n < tot && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (w_valid && lat < 0) lat = cyc;
            if (w_valid && n == stall) begin
                w_ready = 1'b0;
                s_data = w_data; s_eob = w_eob; s_last = w_last; s_addr = mem_addr;
                start = 1'b1; size = 32'd7;   // a start mid-job must be ignored
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    cyc++;
                    chk($sformatf("stall%0d_valid", k), 32'(w_valid), 32'd1);
                    chk($sformatf("stall%0d_data", k), w_data, s_data);
                    chk($sformatf("stall%0d_eob", k), 32'(w_eob), 32'(s_eob));
                    chk($sformatf("stall%0d_last", k), 32'(w_last), 32'(s_last));
                    chk($sformatf("stall%0d_addr", k), 32'(mem_addr), 32'(s_addr));
                end
                start = 1'b0; size = sz; w_ready = 1'b1; stall = -1;
            end
            if (w_valid && w_ready) begin
                got_data[n] = w_data; got_eob[n] = w_eob; got_last[n] = w_last; got_addr[n] = mem_addr;
                n++;
                last_cyc = cyc;
            end
            if (n == abort_at) begin
                reset_n = 1'b0;
                #1;
                chk_idle_outputs("abort");
                @(negedge clk);
                reset_n = 1'b1;
                return;
            end
        end
        chk("job_words", 32'(n), 32'(tot));
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_valid", 32'(w_valid), 32'd0);
        @(negedge clk);
        chk("done_clear", 32'(done), 32'd0);
        chk("latency", 32'(lat), (sz != 0) ? 32'd3 : 32'd1);
        for (int j = 0; j < n; j++) begin
            chk($sformatf("w%0d_data", j), got_data[j], ref_word(j, a, sz));
            chk($sformatf("w%0d_eob", j), 32'(got_eob[j]), 32'(j % 16 == 15));
            chk($sformatf("w%0d_last", j), 32'(got_last[j]), 32'(j == tot - 1));
        end
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; w_ready = 1'b0; message_addr = 32'd0; size = 32'd0;
        repeat (2) @(negedge clk);
        chk_idle_outputs("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // size 0: all generated words at full rate
        run_job(32'd0, 32'd0, -1, -1);
        chk("s0_count", 32'(n), 32'd16);
        chk("s0_w0", got_data[0], 32'h8000_0000);
        chk("s0_w15", got_data[15], 32'd0);
        chk("s0_eob15", 32'(got_eob[15]), 32'd1);
        chk("s0_last15", 32'(got_last[15]), 32'd1);
        chk("s0_rate", 32'(last_cyc - lat), 32'd15);

        // size 3: partial word padded in place
        run_job(32'd0, 32'd3, -1, -1);
        chk("s3_w0", got_data[0], 32'h0123_4580);
        chk("s3_w15", got_data[15], 32'h0000_0018);

        // size 120 with a 5-cycle stall on word 5
        run_job(32'd0, 32'd120, 5, -1);
        chk("s120_count", 32'(n), 32'd48);
        chk("s120_w30", got_data[30], 32'h8000_0000);
        chk("s120_w46", got_data[46], 32'd0);
        chk("s120_w47", got_data[47], 32'h0000_03C0);
        chk("s120_eob15", 32'(got_eob[15]), 32'd1);
        chk("s120_eob31", 32'(got_eob[31]), 32'd1);
        chk("s120_eob47", 32'(got_eob[47]), 32'd1);

        // reset at word 20, then a clean rerun
        run_job(32'd0, 32'd120, -1, 20);
        repeat (3) @(negedge clk);
        chk_idle_outputs("post_reset");
        run_job(32'd0, 32'd120, -1, -1);
        chk("rerun_count", 32'(n), 32'd48);
        chk("rerun_w47", got_data[47], 32'h0000_03C0);

        // size 56 across the 16-bit address wrap
        run_job(32'h0000_FFFE, 32'd56, -1, -1);
        chk("s56_count", 32'(n), 32'd32);
        chk("s56_a0", 32'(got_addr[0]), 32'h0000_FFFE);
        chk("s56_a1", 32'(got_addr[1]), 32'h0000_FFFF);
        chk("s56_a2", 32'(got_addr[2]), 32'h0000_0000);
        chk("s56_a13", 32'(got_addr[13]), 32'h0000_000B);
        chk("s56_w14", got_data[14], 32'h8000_0000);
        chk("s56_w31", got_data[31], 32'h0000_01C0);

        // size 55 still fits one block
        run_job(32'h0000_0100, 32'd55, -1, -1);
        chk("s55_count", 32'(n), 32'd16);
        chk("s55_w14", got_data[14], 32'd0);
        chk("s55_w15", got_data[15], 32'h0000_01B8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
